switch_debounce: RTL and testbench

Conditions the raw 8-position dial-switch inputs before they drive the LED output stage.
- Each bit is synchronised into the clk domain with a 2-flop synchroniser.
- Each bit is then debounced by its own stability counter.
- sw_db is the clean level that the downstream switch-to-LED stage consumes in place of the raw pins.

---
 rtl/sw_pkg.sv | 15 +
 rtl/debounce_bit.sv | 62 ++++++
 rtl/switch_debounce.sv | 70 +++++++
 tb/tb_switch_debounce.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
// ============================================================================
// sw_pkg : shared defaults and types for the dial-switch conditioning block
// Revision: 1.0
// ============================================================================
`default_nettype none

package sw_pkg;
    localparam int SW_WIDTH_DEF  = 8;
    localparam int DB_CYCLES_DEF = 1000000;
    localparam int DB_CNT_W      = $clog2(DB_CYCLES_DEF);

    typedef logic [SW_WIDTH_DEF-1:0] sw_vec_t;
endpackage

`default_nettype wire

// File: rtl/debounce_bit.sv
// ============================================================================
// debounce_bit : one switch bit -- 2-flop synchroniser, stability counter, output flop
// Revision: 1.0
// ============================================================================
`default_nettype none

module debounce_bit
    import sw_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic flip
);

    localparam int              CNT_W    = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DB_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             dout_q;
    logic             dout_d;

    // Any return of s2 to the settled level restarts the whole interval.
    always_comb begin
        cnt_d  = cnt_q;
        dout_d = dout_q;
        if (s2_q == dout_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_TERM) begin
            dout_d = s2_q;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            cnt_q  <= '0;
            dout_q <= 1'b0;
        end else begin
            s1_q   <= din;
            s2_q   <= s1_q;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;
    assign flip = dout_d ^ dout_q;

endmodule

`default_nettype wire

// File: rtl/switch_debounce.sv
// ============================================================================
// switch_debounce : per-bit synchronise + debounce of the dial switches, with change strobe.
// Optional SW_EDGE_EN adds per-bit sw_rise / sw_fall strobes.  Revision: 1.0
// ============================================================================
`default_nettype none

module switch_debounce
    import sw_pkg::*;
#(
    parameter int WIDTH     = SW_WIDTH_DEF,
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_db,
`ifdef SW_EDGE_EN
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
`endif
    output logic             sw_chg
);

    logic [WIDTH-1:0] flip_w;
    logic             sw_chg_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DB_CYCLES (DB_CYCLES)
        ) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (sw_in[i]),
            .dout  (sw_db[i]),
            .flip  (flip_w[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_chg_q <= 1'b0;
        end else begin
            sw_chg_q <= |flip_w;
        end
    end

    assign sw_chg = sw_chg_q;

`ifdef SW_EDGE_EN
    logic [WIDTH-1:0] sw_rise_q;
    logic [WIDTH-1:0] sw_fall_q;

    // A flipping bit rises if it is currently low, falls if currently high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_rise_q <= '0;
            sw_fall_q <= '0;
        end else begin
            sw_rise_q <= flip_w & ~sw_db;
            sw_fall_q <= flip_w &  sw_db;
        end
    end

    assign sw_rise = sw_rise_q;
    assign sw_fall = sw_fall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_switch_debounce.sv
// ============================================================================
// tb_switch_debounce : table-driven, scoreboarded checks of switch_debounce at DB_CYCLES=4
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_switch_debounce;

    localparam int W  = 8;
    localparam int DB = 4;

    typedef struct {
        logic [W-1:0] sw;
        logic [W-1:0] db;
        logic         chg;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] sw_in = '0;
    logic [W-1:0] sw_db;
    logic         sw_chg;
`ifdef SW_EDGE_EN
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    vec_t tbl[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    switch_debounce #(
        .WIDTH     (W),
        .DB_CYCLES (DB)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sw_in  (sw_in),
        .sw_db  (sw_db),
`ifdef SW_EDGE_EN
        .sw_rise(sw_rise),
        .sw_fall(sw_fall),
`endif
        .sw_chg (sw_chg)
    );

    task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic [W-1:0] sw, input logic [W-1:0] db, input logic chg,
                                input logic [W-1:0] rise, input logic [W-1:0] fall);
        vec_t v;
        v.sw = sw; v.db = db; v.chg = chg; v.rise = rise; v.fall = fall;
        tbl.push_back(v);
    endfunction

    function automatic void add_n(input int n, input logic [W-1:0] sw, input logic [W-1:0] db);
        for (int k = 0; k < n; k++) add(sw, db, 1'b0, '0, '0);
    endfunction

    // Drive each row before an edge, queue its expectation, check after the edge.
    task automatic run_table(input string name);
        vec_t v;
        vec_t e;
        for (int k = 0; k < tbl.size(); k++) begin
            v = tbl[k];
            sw_in = v.sw;
            sb.push_back(v);
            tick();
            e = sb.pop_front();
            cmp($sformatf("%s[%0d].sw_db", name, k), sw_db, e.db);
            cmp($sformatf("%s[%0d].sw_chg", name, k), {7'd0, sw_chg}, {7'd0, e.chg});
`ifdef SW_EDGE_EN
            cmp($sformatf("%s[%0d].sw_rise", name, k), sw_rise, e.rise);
            cmp($sformatf("%s[%0d].sw_fall", name, k), sw_fall, e.fall);
`endif
        end
        tbl.delete();
    endtask

    task automatic pulse_reset();
        sw_in = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // 1. Reset held with all switches on, then power-up capture.
        sw_in = 8'hFF;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            cmp("rst_hold.sw_db", sw_db, 8'h00);
            cmp("rst_hold.sw_chg", {7'd0, sw_chg}, 8'h00);
        end
        rst_n = 1'b1;
        add_n(5, 8'hFF, 8'h00);
        add(8'hFF, 8'hFF, 1'b1, 8'hFF, 8'h00);
        add_n(2, 8'hFF, 8'hFF);
        run_table("powerup");
        pulse_reset();

        // 2. Clean single-bit step.
        add_n(5, 8'h01, 8'h00);
        add(8'h01, 8'h01, 1'b1, 8'h01, 8'h00);
        add_n(2, 8'h01, 8'h01);
        run_table("step");
        pulse_reset();

        // 3. Bounce on bit 3 with 2-cycle periods, then settle high.
        add_n(2, 8'h08, 8'h00); add_n(2, 8'h00, 8'h00);
        add_n(2, 8'h08, 8'h00); add_n(2, 8'h00, 8'h00);
        add_n(5, 8'h08, 8'h00);
        add(8'h08, 8'h08, 1'b1, 8'h08, 8'h00);
        add_n(2, 8'h08, 8'h08);
        run_table("bounce");
        pulse_reset();

        // 4. Single-cycle glitch on bit 7.
        add(8'h80, 8'h00, 1'b0, '0, '0);
        add_n(8, 8'h00, 8'h00);
        run_table("glitch");

        // 5. Bits 0 and 5 together, up then down.
        add_n(5, 8'h21, 8'h00);
        add(8'h21, 8'h21, 1'b1, 8'h21, 8'h00);
        add_n(2, 8'h21, 8'h21);
        add_n(5, 8'h00, 8'h21);
        add(8'h00, 8'h00, 1'b1, 8'h00, 8'h21);
        add_n(2, 8'h00, 8'h00);
        add_n(5, 8'h21, 8'h00);
        add(8'h21, 8'h21, 1'b1, 8'h21, 8'h00);
        add_n(1, 8'h21, 8'h21);
        run_table("multi");

        // 6. Reset two cycles into a pending change (bit 5 falling).
        add_n(2, 8'h01, 8'h21);
        run_table("midcnt_pre");
        rst_n = 1'b0;
        #1;
        cmp("midcnt_async.sw_db", sw_db, 8'h00);
        cmp("midcnt_async.sw_chg", {7'd0, sw_chg}, 8'h00);
`ifdef SW_EDGE_EN
        cmp("midcnt_async.sw_rise", sw_rise, 8'h00);
        cmp("midcnt_async.sw_fall", sw_fall, 8'h00);
`endif
        for (int k = 0; k < 2; k++) begin
            tick();
            cmp("midcnt_hold.sw_db", sw_db, 8'h00);
        end
        rst_n = 1'b1;
        add_n(5, 8'h01, 8'h00);
        add(8'h01, 8'h01, 1'b1, 8'h01, 8'h00);
        add_n(2, 8'h01, 8'h01);
        run_table("midcnt_post");

        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
